// File: rtl/plab5_mcore_mem_net_tag_adapter_pkg.sv
// Shared constants and message-width helpers for the core-side mem/net tag adapter.
// Mem request layout (MSB..LSB): type|opaque|addr|len|data; mem response: type|opaque|test|len|data.
package plab5_mcore_mem_net_tag_adapter_pkg;

  localparam int unsigned INTERLEAVE_LINE = 0;
  localparam int unsigned INTERLEAVE_XOR  = 1;

  localparam int unsigned MEM_TYPE_NBITS = 3;
  localparam int unsigned MEM_TEST_NBITS = 2;

  function automatic int unsigned mem_len_nbits(input int unsigned data_nbits);
    return $clog2(data_nbits / 8);
  endfunction

  function automatic int unsigned memreq_nbits(input int unsigned o, input int unsigned a,
                                               input int unsigned d);
    return MEM_TYPE_NBITS + o + a + mem_len_nbits(d) + d;
  endfunction

  function automatic int unsigned memresp_nbits(input int unsigned o, input int unsigned d);
    return MEM_TYPE_NBITS + o + MEM_TEST_NBITS + mem_len_nbits(d) + d;
  endfunction

endpackage

// File: rtl/plab5_mcore_mem_net_tag_adapter_freelist.sv
// Tag free list: free bit-vector, lowest-index-free allocation, and allocated-tag count.
module plab5_mcore_TagFreeList #(
  parameter  int unsigned p_num_tags = 4,
  localparam int unsigned TW         = $clog2(p_num_tags),
  localparam int unsigned CW         = $clog2(p_num_tags + 1)
)(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alloc_val_i,
  output logic                  alloc_rdy_o,
  output logic [TW-1:0]         alloc_tag_o,
  input  logic                  free_val_i,
  input  logic [TW-1:0]         free_tag_i,
  output logic [p_num_tags-1:0] busy_o,
  output logic [CW-1:0]         count_o
);

  logic [p_num_tags-1:0] free_q, free_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  found;
  logic                  do_alloc;

  always_comb begin
    alloc_tag_o = '0;
    found       = 1'b0;
    for (int i = 0; i < int'(p_num_tags); i++) begin
      if (free_q[i] && !found) begin
        alloc_tag_o = TW'(i);
        found       = 1'b1;
      end
    end
  end

  assign alloc_rdy_o = |free_q;
  assign do_alloc    = alloc_val_i && alloc_rdy_o;

  // Alloc picks from the start-of-cycle vector, so a tag freed now is reusable next cycle.
  always_comb begin
    free_d  = free_q;
    count_d = count_q;
    if (do_alloc)   free_d[alloc_tag_o] = 1'b0;
    if (free_val_i) free_d[free_tag_i]  = 1'b1;
    if (do_alloc && !free_val_i)      count_d = count_q + CW'(1);
    else if (!do_alloc && free_val_i) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      free_q  <= '1;
      count_q <= '0;
    end else begin
      free_q  <= free_d;
      count_q <= count_d;
    end
  end

  assign busy_o  = ~free_q;
  assign count_o = count_q;

endmodule

// File: rtl/plab5_mcore_mem_net_tag_adapter.sv
// Core-side adapter: tags memory requests with a net opaque ID, routes them to a bank,
// and restores the original memory opaque on the matching response.
module plab5_mcore_mem_net_tag_adapter
  import plab5_mcore_mem_net_tag_adapter_pkg::*;
#(
  parameter  int unsigned p_net_src           = 0,
  parameter  int unsigned p_num_ports         = 4,
  parameter  int unsigned p_mem_opaque_nbits  = 8,
  parameter  int unsigned p_mem_addr_nbits    = 32,
  parameter  int unsigned p_mem_data_nbits    = 32,
  parameter  int unsigned p_net_opaque_nbits  = 4,
  parameter  int unsigned p_net_srcdest_nbits = 3,
  parameter  int unsigned p_cacheline_nwords  = 4,
  parameter  int unsigned p_num_banks         = 4,
  parameter  int unsigned p_interleave_mode   = 0,
  parameter  int unsigned p_max_outstanding   = 4,
  localparam int unsigned MREQ_NBITS  = memreq_nbits(p_mem_opaque_nbits, p_mem_addr_nbits, p_mem_data_nbits),
  localparam int unsigned MRESP_NBITS = memresp_nbits(p_mem_opaque_nbits, p_mem_data_nbits),
  localparam int unsigned NREQ_NBITS  = 2*p_net_srcdest_nbits + p_net_opaque_nbits + MREQ_NBITS,
  localparam int unsigned NRESP_NBITS = 2*p_net_srcdest_nbits + p_net_opaque_nbits + MRESP_NBITS,
  localparam int unsigned CNT_NBITS   = $clog2(p_max_outstanding + 1)
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sd,
  input  logic [MREQ_NBITS-1:0]  memreq_msg,
  input  logic                   memreq_val,
  output logic                   memreq_rdy,
  output logic [NREQ_NBITS-1:0]  netreq_msg,
  output logic                   netreq_val,
  input  logic                   netreq_rdy,
  input  logic [NRESP_NBITS-1:0] netresp_msg,
  input  logic                   netresp_val,
  output logic                   netresp_rdy,
  output logic [MRESP_NBITS-1:0] memresp_msg,
  output logic                   memresp_val,
  input  logic                   memresp_rdy,
  output logic [CNT_NBITS-1:0]   num_outstanding,
  output logic                   tag_err
);

  localparam int unsigned SD_NBITS     = p_net_srcdest_nbits;
  localparam int unsigned NO_NBITS     = p_net_opaque_nbits;
  localparam int unsigned MO_NBITS     = p_mem_opaque_nbits;
  localparam int unsigned TAG_NBITS    = $clog2(p_max_outstanding);
  localparam int unsigned LEN_NBITS    = mem_len_nbits(p_mem_data_nbits);
  localparam int unsigned REQ_ADDR_LSB = LEN_NBITS + p_mem_data_nbits;
  localparam int unsigned REQ_OPQ_LSB  = REQ_ADDR_LSB + p_mem_addr_nbits;
  localparam int unsigned RESP_OPQ_LSB = MEM_TEST_NBITS + LEN_NBITS + p_mem_data_nbits;
  localparam int unsigned BANK_LSB     = REQ_ADDR_LSB + 2 + $clog2(p_cacheline_nwords);
  localparam int unsigned BANK_NBITS   = $clog2(p_num_banks);
  localparam logic [NO_NBITS:0] MAX_TAGS = (NO_NBITS+1)'(p_max_outstanding);

  logic                   live_q;
  logic                   netreq_val_q, netreq_val_d;
  logic [NREQ_NBITS-1:0]  netreq_msg_q;
  logic                   memresp_val_q, memresp_val_d;
  logic [MRESP_NBITS-1:0] memresp_msg_q;
  logic                   tag_err_q, tag_err_d;
  logic [MO_NBITS-1:0]    tag_table_q [p_max_outstanding];

  logic                         fl_has_free;
  logic [TAG_NBITS-1:0]         alloc_tag;
  logic [p_max_outstanding-1:0] tag_busy;
  logic                         req_go;
  logic [SD_NBITS-1:0]          bank;
  logic [NO_NBITS-1:0]          resp_opq;
  logic [TAG_NBITS-1:0]         resp_tag;
  logic                         resp_in_range, resp_hit, resp_go, resp_free;
  logic                         unused_bits;

  plab5_mcore_TagFreeList #(.p_num_tags(p_max_outstanding)) u_freelist (
    .clk_i       (clk),
    .rst_i       (reset),
    .alloc_val_i (req_go),
    .alloc_rdy_o (fl_has_free),
    .alloc_tag_o (alloc_tag),
    .free_val_i  (resp_free),
    .free_tag_i  (resp_tag),
    .busy_o      (tag_busy),
    .count_o     (num_outstanding)
  );

  // Request stage: memreq -> netreq register
  assign memreq_rdy   = live_q && fl_has_free && (!netreq_val_q || netreq_rdy);
  assign req_go       = memreq_val && memreq_rdy;
  assign netreq_val_d = req_go || (netreq_val_q && !netreq_rdy);

  generate
    if (BANK_NBITS == 0) begin : g_one_bank
      assign bank = '0;
    end else begin : g_banked
      logic [BANK_NBITS-1:0] fold;
      if (p_interleave_mode == INTERLEAVE_XOR) begin : g_xor
        assign fold = memreq_msg[BANK_LSB +: BANK_NBITS]
                    ^ memreq_msg[BANK_LSB+BANK_NBITS +: BANK_NBITS];
      end else begin : g_line
        assign fold = memreq_msg[BANK_LSB +: BANK_NBITS];
      end
      assign bank = SD_NBITS'(fold);
    end
  endgenerate

  // Response stage: netresp -> memresp register
  assign resp_opq      = netresp_msg[MRESP_NBITS +: NO_NBITS];
  assign resp_tag      = resp_opq[TAG_NBITS-1:0];
  assign resp_in_range = ({1'b0, resp_opq} < MAX_TAGS);
  assign resp_hit      = resp_in_range && tag_busy[resp_tag];
  assign netresp_rdy   = !memresp_val_q || memresp_rdy;
  assign resp_go       = netresp_val && netresp_rdy;
  assign resp_free     = resp_go && resp_hit;
  assign memresp_val_d = resp_free || (memresp_val_q && !memresp_rdy);
  assign tag_err_d     = tag_err_q || (resp_go && !resp_hit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_q        <= 1'b0;
      netreq_val_q  <= 1'b0;
      memresp_val_q <= 1'b0;
      tag_err_q     <= 1'b0;
    end else begin
      live_q        <= 1'b1;
      netreq_val_q  <= netreq_val_d;
      memresp_val_q <= memresp_val_d;
      tag_err_q     <= tag_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (req_go) begin
      netreq_msg_q           <= {bank, SD_NBITS'(p_net_src), NO_NBITS'(alloc_tag), memreq_msg};
      tag_table_q[alloc_tag] <= memreq_msg[REQ_OPQ_LSB +: MO_NBITS];
    end
    if (resp_free) begin
      memresp_msg_q <= {netresp_msg[MRESP_NBITS-1 -: MEM_TYPE_NBITS], tag_table_q[resp_tag],
                        netresp_msg[RESP_OPQ_LSB-1:0]};
    end
  end

  // Response routing fields and the incoming mem opaque are intentionally discarded.
  assign unused_bits = ^{sd, netresp_msg[NRESP_NBITS-1 -: 2*SD_NBITS],
                         netresp_msg[RESP_OPQ_LSB +: MO_NBITS]};

  assign netreq_msg  = netreq_msg_q;
  assign netreq_val  = netreq_val_q;
  assign memresp_msg = memresp_msg_q;
  assign memresp_val = memresp_val_q;
  assign tag_err     = tag_err_q;

endmodule

// File: tb/tb_plab5_mcore_mem_net_tag_adapter.sv
// Directed bench for the mem/net tag adapter: default config plus XOR-hash and single-bank variants.
module tb_plab5_mcore_mem_net_tag_adapter;

  localparam int MREQ = 77, MRESP = 47, NREQ = 87, NRESP = 57;

  logic clk = 1'b0;
  logic reset, sd;
  logic [MREQ-1:0]  memreq_msg;
  logic             memreq_val, memreq_rdy;
  logic [NREQ-1:0]  netreq_msg, netreq_msg_x, netreq_msg_s;
  logic             netreq_val, netreq_rdy;
  logic [NRESP-1:0] netresp_msg;
  logic             netresp_val, netresp_rdy;
  logic [MRESP-1:0] memresp_msg;
  logic             memresp_val, memresp_rdy;
  logic [2:0]       num_out;
  logic             tag_err;

  logic             unused_x_memreq_rdy, unused_x_netreq_val, unused_x_netresp_rdy;
  logic             unused_x_memresp_val, unused_x_tag_err;
  logic [MRESP-1:0] unused_x_memresp_msg;
  logic [2:0]       unused_x_num;
  logic             unused_s_memreq_rdy, unused_s_netreq_val, unused_s_netresp_rdy;
  logic             unused_s_memresp_val, unused_s_tag_err;
  logic [MRESP-1:0] unused_s_memresp_msg;
  logic [2:0]       unused_s_num;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  plab5_mcore_mem_net_tag_adapter dut (
    .clk(clk), .reset(reset), .sd(sd),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(memreq_rdy),
    .netreq_msg(netreq_msg), .netreq_val(netreq_val), .netreq_rdy(netreq_rdy),
    .netresp_msg(netresp_msg), .netresp_val(netresp_val), .netresp_rdy(netresp_rdy),
    .memresp_msg(memresp_msg), .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
    .num_outstanding(num_out), .tag_err(tag_err)
  );

  plab5_mcore_mem_net_tag_adapter #(.p_interleave_mode(1)) dut_x (
    .clk(clk), .reset(reset), .sd(sd),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(unused_x_memreq_rdy),
    .netreq_msg(netreq_msg_x), .netreq_val(unused_x_netreq_val), .netreq_rdy(netreq_rdy),
    .netresp_msg(netresp_msg), .netresp_val(netresp_val), .netresp_rdy(unused_x_netresp_rdy),
    .memresp_msg(unused_x_memresp_msg), .memresp_val(unused_x_memresp_val),
    .memresp_rdy(memresp_rdy), .num_outstanding(unused_x_num), .tag_err(unused_x_tag_err)
  );

  plab5_mcore_mem_net_tag_adapter #(.p_num_banks(1)) dut_s (
    .clk(clk), .reset(reset), .sd(sd),
    .memreq_msg(memreq_msg), .memreq_val(memreq_val), .memreq_rdy(unused_s_memreq_rdy),
    .netreq_msg(netreq_msg_s), .netreq_val(unused_s_netreq_val), .netreq_rdy(netreq_rdy),
    .netresp_msg(netresp_msg), .netresp_val(netresp_val), .netresp_rdy(unused_s_netresp_rdy),
    .memresp_msg(unused_s_memresp_msg), .memresp_val(unused_s_memresp_val),
    .memresp_rdy(memresp_rdy), .num_outstanding(unused_s_num), .tag_err(unused_s_tag_err)
  );

  function automatic logic [MREQ-1:0] mk_req(input logic [7:0] op, input logic [31:0] addr);
    return {3'd0, op, addr, 2'd2, addr ^ 32'hA5A5_0000};
  endfunction

  function automatic logic [NRESP-1:0] mk_resp(input logic [3:0] tag, input logic [7:0] op);
    return {3'd0, 3'd5, tag, 3'd0, op, 2'd0, 2'd2, {28'hBEEF000, tag}};
  endfunction

  function automatic logic [MRESP-1:0] exp_resp(input logic [3:0] tag, input logic [7:0] op);
    return {3'd0, op, 2'd0, 2'd2, {28'hBEEF000, tag}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; sd = 1'b0;
    memreq_val = 1'b0; netresp_val = 1'b0; netreq_rdy = 1'b1; memresp_rdy = 1'b1;
    memreq_msg = '0; netresp_msg = '0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (netreq_val !== 1'b0) begin bad++; $display("FAIL rst_netreq_val got=%b want=0", netreq_val); end
    total++; if (memresp_val !== 1'b0) begin bad++; $display("FAIL rst_memresp_val got=%b want=0", memresp_val); end
    total++; if (num_out !== 3'd0) begin bad++; $display("FAIL rst_num got=%0d want=0", num_out); end
    total++; if (tag_err !== 1'b0) begin bad++; $display("FAIL rst_tag_err got=%b want=0", tag_err); end
    reset = 1'b0;
    #1;
    total++; if (memreq_rdy !== 1'b0) begin bad++; $display("FAIL rst_rdy_early got=%b want=0", memreq_rdy); end
    step();
    total++; if (memreq_rdy !== 1'b1) begin bad++; $display("FAIL rst_rdy_first got=%b want=1", memreq_rdy); end
  endtask

  task automatic test_single();
    memreq_msg = mk_req(8'h5A, 32'h0000_0040);
    memreq_val = 1'b1;
    total++; if (netreq_val !== 1'b0) begin bad++; $display("FAIL single_pre_val got=%b want=0", netreq_val); end
    step();
    memreq_val = 1'b0;
    total++; if (netreq_val !== 1'b1) begin bad++; $display("FAIL single_val got=%b want=1", netreq_val); end
    total++; if (netreq_msg !== {3'd0, 3'd0, 4'd0, mk_req(8'h5A, 32'h40)}) begin bad++;
      $display("FAIL single_msg got=%h want=%h", netreq_msg, {3'd0, 3'd0, 4'd0, mk_req(8'h5A, 32'h40)}); end
    total++; if (netreq_msg_x[86:84] !== 3'd1) begin bad++; $display("FAIL single_xor_dest got=%0d want=1", netreq_msg_x[86:84]); end
    total++; if (netreq_msg_s[86:84] !== 3'd0) begin bad++; $display("FAIL single_1bank_dest got=%0d want=0", netreq_msg_s[86:84]); end
    total++; if (num_out !== 3'd1) begin bad++; $display("FAIL single_num got=%0d want=1", num_out); end
    step();
    total++; if (netreq_val !== 1'b0) begin bad++; $display("FAIL single_drain got=%b want=0", netreq_val); end
  endtask

  task automatic test_response();
    netresp_msg = mk_resp(4'd0, 8'h00);
    netresp_val = 1'b1;
    step();
    netresp_val = 1'b0;
    memresp_rdy = 1'b0;
    total++; if (memresp_val !== 1'b1) begin bad++; $display("FAIL resp_val got=%b want=1", memresp_val); end
    total++; if (memresp_msg !== exp_resp(4'd0, 8'h5A)) begin bad++;
      $display("FAIL resp_msg got=%h want=%h", memresp_msg, exp_resp(4'd0, 8'h5A)); end
    total++; if (num_out !== 3'd0) begin bad++; $display("FAIL resp_num got=%0d want=0", num_out); end
    step();
    total++; if (memresp_val !== 1'b1 || memresp_msg !== exp_resp(4'd0, 8'h5A)) begin bad++;
      $display("FAIL resp_hold got=%b/%h want=1/%h", memresp_val, memresp_msg, exp_resp(4'd0, 8'h5A)); end
    total++; if (netresp_rdy !== 1'b0) begin bad++; $display("FAIL resp_backpress got=%b want=0", netresp_rdy); end
    memresp_rdy = 1'b1;
    step();
    total++; if (memresp_val !== 1'b0) begin bad++; $display("FAIL resp_drain got=%b want=0", memresp_val); end
  endtask

  task automatic test_interleave();
    memreq_msg = mk_req(8'h66, 32'h0000_01D0);
    memreq_val = 1'b1;
    step();
    memreq_val = 1'b0;
    total++; if (netreq_msg[86:84] !== 3'd1) begin bad++; $display("FAIL line_dest got=%0d want=1", netreq_msg[86:84]); end
    total++; if (netreq_msg_x[86:84] !== 3'd2) begin bad++; $display("FAIL xor_dest got=%0d want=2", netreq_msg_x[86:84]); end
    total++; if (netreq_msg_s[86:84] !== 3'd0) begin bad++; $display("FAIL onebank_dest got=%0d want=0", netreq_msg_s[86:84]); end
    netresp_msg = mk_resp(4'd0, 8'h00);
    netresp_val = 1'b1;
    step();
    netresp_val = 1'b0;
    total++; if (memresp_msg !== exp_resp(4'd0, 8'h66)) begin bad++;
      $display("FAIL interleave_resp got=%h want=%h", memresp_msg, exp_resp(4'd0, 8'h66)); end
    step();
  endtask

  task automatic test_fill();
    memreq_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      memreq_msg = mk_req(8'(8'h10 + i), 32'(32'h100 * i));
      total++; if (memreq_rdy !== 1'b1) begin bad++; $display("FAIL fill_rdy%0d got=%b want=1", i, memreq_rdy); end
      step();
      total++; if (netreq_val !== 1'b1 || netreq_msg[80:77] !== 4'(i)) begin bad++;
        $display("FAIL fill_tag%0d got=%b/%0d want=1/%0d", i, netreq_val, netreq_msg[80:77], i); end
      total++; if (num_out !== 3'(i + 1)) begin bad++; $display("FAIL fill_num%0d got=%0d want=%0d", i, num_out, i + 1); end
    end
    memreq_msg = mk_req(8'h77, 32'h0000_0080);
    total++; if (memreq_rdy !== 1'b0) begin bad++; $display("FAIL full_rdy got=%b want=0", memreq_rdy); end
    step();
    total++; if (netreq_val !== 1'b0 || num_out !== 3'd4) begin bad++;
      $display("FAIL full_hold got=%b/%0d want=0/4", netreq_val, num_out); end
    netresp_msg = mk_resp(4'd2, 8'h00);
    netresp_val = 1'b1;
    step();
    netresp_val = 1'b0;
    total++; if (memresp_msg !== exp_resp(4'd2, 8'h12)) begin bad++;
      $display("FAIL free2_resp got=%h want=%h", memresp_msg, exp_resp(4'd2, 8'h12)); end
    total++; if (num_out !== 3'd3 || memreq_rdy !== 1'b1) begin bad++;
      $display("FAIL free2_state got=%0d/%b want=3/1", num_out, memreq_rdy); end
    step();
    memreq_val = 1'b0;
    total++; if (netreq_msg[80:77] !== 4'd2 || netreq_msg[73:66] !== 8'h77) begin bad++;
      $display("FAIL reuse2 got=%0d/%h want=2/77", netreq_msg[80:77], netreq_msg[73:66]); end
    total++; if (num_out !== 3'd4) begin bad++; $display("FAIL reuse2_num got=%0d want=4", num_out); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ops [4];
    ops = '{8'h10, 8'h11, 8'h77, 8'h13};
    netresp_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      netresp_msg = mk_resp(4'(i), 8'hEE);
      step();
      total++; if (memresp_val !== 1'b1 || memresp_msg !== exp_resp(4'(i), ops[i])) begin bad++;
        $display("FAIL b2b_resp%0d got=%b/%h want=1/%h", i, memresp_val, memresp_msg, exp_resp(4'(i), ops[i])); end
      total++; if (num_out !== 3'(3 - i)) begin bad++; $display("FAIL b2b_num%0d got=%0d want=%0d", i, num_out, 3 - i); end
    end
    netresp_val = 1'b0;
    step();
    total++; if (memresp_val !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", memresp_val); end
  endtask

  task automatic test_same_cycle();
    memreq_msg = mk_req(8'h21, 32'h0);
    memreq_val = 1'b1;
    step();
    memreq_msg  = mk_req(8'h22, 32'h10);
    netresp_msg = mk_resp(4'd0, 8'h00);
    netresp_val = 1'b1;
    step();
    netresp_val = 1'b0;
    total++; if (netreq_msg[80:77] !== 4'd1) begin bad++; $display("FAIL same_alloc got=%0d want=1", netreq_msg[80:77]); end
    total++; if (memresp_msg !== exp_resp(4'd0, 8'h21)) begin bad++;
      $display("FAIL same_resp got=%h want=%h", memresp_msg, exp_resp(4'd0, 8'h21)); end
    total++; if (num_out !== 3'd1) begin bad++; $display("FAIL same_num got=%0d want=1", num_out); end
    memreq_msg = mk_req(8'h23, 32'h20);
    step();
    memreq_val = 1'b0;
    total++; if (netreq_msg[80:77] !== 4'd0 || num_out !== 3'd2) begin bad++;
      $display("FAIL same_reuse got=%0d/%0d want=0/2", netreq_msg[80:77], num_out); end
    netresp_msg = mk_resp(4'd1, 8'h00);
    netresp_val = 1'b1;
    step();
    total++; if (memresp_msg !== exp_resp(4'd1, 8'h22)) begin bad++;
      $display("FAIL same_drain1 got=%h want=%h", memresp_msg, exp_resp(4'd1, 8'h22)); end
    netresp_msg = mk_resp(4'd0, 8'h00);
    step();
    netresp_val = 1'b0;
    total++; if (memresp_msg !== exp_resp(4'd0, 8'h23) || num_out !== 3'd0) begin bad++;
      $display("FAIL same_drain0 got=%h/%0d want=%h/0", memresp_msg, num_out, exp_resp(4'd0, 8'h23)); end
    step();
  endtask

  task automatic test_bad_tag();
    netresp_msg = mk_resp(4'd3, 8'h55);
    netresp_val = 1'b1;
    total++; if (tag_err !== 1'b0) begin bad++; $display("FAIL badtag_pre got=%b want=0", tag_err); end
    step();
    netresp_val = 1'b0;
    total++; if (memresp_val !== 1'b0) begin bad++; $display("FAIL badtag_drop got=%b want=0", memresp_val); end
    total++; if (tag_err !== 1'b1 || num_out !== 3'd0) begin bad++;
      $display("FAIL badtag_err got=%b/%0d want=1/0", tag_err, num_out); end
    repeat (3) step();
    total++; if (tag_err !== 1'b1) begin bad++; $display("FAIL badtag_sticky got=%b want=1", tag_err); end
  endtask

  task automatic test_stall_reset();
    int n;
    netreq_rdy = 1'b0;
    memreq_msg = mk_req(8'h31, 32'h40);
    memreq_val = 1'b1;
    step();
    memreq_msg = mk_req(8'h32, 32'h50);
    for (int k = 0; k < 3; k++) begin
      total++; if (netreq_val !== 1'b1 || netreq_msg !== {3'd0, 3'd0, 4'd0, mk_req(8'h31, 32'h40)}) begin bad++;
        $display("FAIL stall_hold%0d got=%b/%h want=1", k, netreq_val, netreq_msg); end
      total++; if (memreq_rdy !== 1'b0 || num_out !== 3'd1) begin bad++;
        $display("FAIL stall_rdy%0d got=%b/%0d want=0/1", k, memreq_rdy, num_out); end
      step();
    end
    memreq_val = 1'b0;
    #2 reset = 1'b1;
    #1;
    total++; if (netreq_val !== 1'b0 || num_out !== 3'd0) begin bad++;
      $display("FAIL midrst got=%b/%0d want=0/0", netreq_val, num_out); end
    total++; if (tag_err !== 1'b0) begin bad++; $display("FAIL midrst_err got=%b want=0", tag_err); end
    @(posedge clk);
    #1 reset = 1'b0;
    netreq_rdy = 1'b1;
    n = 0;
    while (memreq_rdy !== 1'b1 && n < 5) begin
      step();
      n++;
    end
    total++; if (memreq_rdy !== 1'b1) begin bad++; $display("FAIL postrst_timeout got=%b want=1", memreq_rdy); end
    memreq_msg = mk_req(8'h41, 32'h0);
    memreq_val = 1'b1;
    step();
    memreq_val = 1'b0;
    total++; if (netreq_msg[80:77] !== 4'd0 || netreq_msg[73:66] !== 8'h41 || num_out !== 3'd1) begin bad++;
      $display("FAIL postrst_tag got=%0d/%h/%0d want=0/41/1", netreq_msg[80:77], netreq_msg[73:66], num_out); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_response();
    test_interleave();
    test_fill();
    test_back_to_back();
    test_same_cycle();
    test_bad_tag();
    test_stall_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
